// File: rtl/count_display.sv
// Two-digit decimal display of a 4-bit up-counter value, multiplexed on a
// common-anode 7-segment pair, with F->0 wrap detection and a wrap counter.
module count_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_pulse,
  output logic [7:0] wrap_count,
  output logic       change_pulse
);

  logic [3:0]              count_q;
  logic [REFRESH_BITS-1:0] prescaler;
  logic                    digit_sel;

  logic       tens;
  logic [3:0] ones;
  logic [3:0] digit_val;
  logic [6:0] seg_next;
  logic [1:0] an_next;
  logic       prescaler_max;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  always_comb begin
    tens          = (count_q >= 4'd10);
    ones          = tens ? (count_q - 4'd10) : count_q;
    digit_val     = digit_sel ? {3'b000, tens} : ones;
    prescaler_max = (prescaler == {REFRESH_BITS{1'b1}});
    an_next       = digit_sel ? 2'b01 : 2'b10;
    // A zero tens digit is blanked rather than shown as a leading zero.
    if (digit_sel && !tens) seg_next = 7'b1111111;
    else                    seg_next = pattern(digit_val);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q      <= 4'h0;
      prescaler    <= '0;
      digit_sel    <= 1'b0;
      seg          <= 7'b1111111;
      an           <= 2'b11;
      wrap_pulse   <= 1'b0;
      wrap_count   <= 8'h00;
      change_pulse <= 1'b0;
    end else begin
      count_q      <= count_in;
      prescaler    <= prescaler + 1'b1;
      digit_sel    <= digit_sel ^ prescaler_max;
      seg          <= seg_next;
      an           <= an_next;
      change_pulse <= (count_in != count_q);
      // Only consecutive samples F then 0 count as an upstream wrap.
      if (count_q == 4'hF && count_in == 4'h0) begin
        wrap_pulse <= 1'b1;
        wrap_count <= wrap_count + 8'd1;
      end else begin
        wrap_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter REFRESH_BITS, default 16, sets the width of the digit-refresh prescaler; each digit is shown for 2^REFRESH_BITS clocks.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset; synchronous, active-high.
REQ-004 count_in  input  4  binary count from the upstream 4-bit up counter, range 0x0-0xF.
REQ-005 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}; registered.
REQ-006 an  output  2  digit enables, active-low; an[0] is the ones digit, an[1] the tens digit; registered.
REQ-007 wrap_pulse  output  1  one-cycle strobe on each upstream F->0 wrap; registered.
REQ-008 wrap_count  output  8  number of wraps seen since clear, modulo 256; registered.
REQ-009 change_pulse  output  1  one-cycle strobe whenever count_in differs from the previously sampled value; registered.

Function
REQ-010 Input register: count_q <= count_in on every non-clear cycle.
REQ-011 Decimal split from count_q:
- tens = 1 when count_q >= 10, else 0.
- ones = count_q - 10*tens, range 0-9.
REQ-012 Prescaler: REFRESH_BITS-bit counter, +1 every non-clear cycle, wraps at all-ones -> 0.
REQ-013 Digit select: digit_sel toggles on the cycle the prescaler is all-ones, else holds.
REQ-014 Display register, every non-clear cycle:
- digit_sel=0: an <= 2'b10, seg <= pattern(ones).
- digit_sel=1: an <= 2'b01, seg <= pattern(tens).
REQ-015 Leading-zero blanking: digit_sel=1 and tens=0 -> seg <= 7'b1111111; an still <= 2'b01.
REQ-016 Segment patterns, fixed:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-017 Latency: count_in to seg/an is 2 clocks while the corresponding digit is selected; a digit not currently selected updates when it is next selected.
REQ-018 wrap_pulse <= (count_q==4'hF && count_in==4'h0).
- Asserts in the same cycle count_q first shows 0.
- Width exactly 1 cycle.
REQ-019 wrap_count increments by 1 in the same edge that sets wrap_pulse; 255 -> 0 with no saturation and no flag.
REQ-020 change_pulse <= (count_in != count_q); asserts for each differing sample, so consecutive changes give consecutive high cycles.
REQ-021 Other transitions into 0 (e.g. 0x7 -> 0x0, or the upstream counter cleared) shall not assert wrap_pulse; they do assert change_pulse.
REQ-022 Jumps or holds of count_in are legal:
- Display follows the sampled value.
- Only the exact F->0 sequence of consecutive samples counts as a wrap.

Reset
REQ-023 clear=1 at an edge sets all of the following; clear dominates every other update:
- count_q=0, prescaler=0, digit_sel=0.
- seg=7'b1111111, an=2'b11.
- wrap_pulse=0, change_pulse=0, wrap_count=0.
REQ-024 Held clear keeps all outputs at their reset values; no asynchronous path exists.
REQ-025 First edge after clear deasserts: an=2'b10, seg=pattern(0) (count_q=0 after reset).
REQ-026 Clear mid-operation, including in a cycle where F->0 would be detected:
- Wrap is discarded; wrap_count=0.
- Detection restarts from count_q=0.

Verification (REFRESH_BITS=2, so the digit toggles every 4 clocks)
REQ-027 Reset: clear=1 for 3 cycles with count_in=0x9 -> seg=1111111, an=11, wrap_count=0 throughout; first cycle after release -> an=10, seg=1000000.
REQ-028 Decimal display: hold count_in=0xC for 16 cycles ->
- Ones phase: an=10, seg=0100100 ("2").
- Tens phase: an=01, seg=1111001 ("1").
- Phases alternate every 4 cycles.
REQ-029 Blanking: hold count_in=0x7 -> tens phase shows an=01, seg=1111111; ones phase shows seg=1111000.
REQ-030 Wrap: drive count_in 0x0..0xF then 0x0, one step per clock, repeated 3 times ->
- Exactly 3 wrap_pulse cycles, each when count_q=0.
- wrap_count ends at 3.
- change_pulse high on every step cycle.
REQ-031 Non-wrap zero and rollover:
- 0x7 -> 0x0 gives change_pulse=1 and wrap_pulse=0.
- 256 F->0 wraps take wrap_count 255 -> 0.
REQ-032 Clear mid-wrap: count_in=0xF, then 0x0 with clear=1 on that edge -> wrap_pulse=0, wrap_count=0; a later F->0 gives wrap_count=1.
